// File: rtl/audio_sequencer.sv
// rtl/audio_sequencer.sv - sequence RAM plus tone/gap playback and live-button control of the tone generator
module audio_sequencer #(
  parameter int SEQ_DEPTH   = 32,
  parameter int IDX_W       = 5,
  parameter int TONE_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000,
  parameter int CNT_W       = 25
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             seq_wr_en,
  input  logic [IDX_W-1:0] seq_wr_addr,
  input  logic [1:0]       seq_wr_color,
  input  logic [IDX_W:0]   seq_len,
  input  logic             start,
  input  logic             abort,
  input  logic             btn_down,
  input  logic [1:0]       btn_color,
  output logic             play_audio,
  output logic [1:0]       color,
  output logic             on_off,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] cur_index
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TONE,
    S_GAP,
    S_MANUAL
  } state_t;

  localparam logic [CNT_W-1:0] TONE_LAST = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W:0]   DEPTH_LEN = (IDX_W+1)'(SEQ_DEPTH);

  logic [1:0] ram [SEQ_DEPTH];

  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W:0]   len, len_n;
  logic             btn_prev;
  logic             abort_pend, abort_pend_n;
  logic             play_n, on_off_n, busy_n, done_n;
  logic [1:0]       color_n;
  logic [IDX_W:0]   idx_inc;
  logic             btn_rise;

  // Sequence RAM: no reset, writable at any time, read asynchronously at tone start.
  always_ff @(posedge clock) begin
    if (seq_wr_en) begin
      ram[seq_wr_addr] <= seq_wr_color;
    end
  end

  assign idx_inc  = {1'b0, cur_index} + (IDX_W+1)'(1);
  assign btn_rise = btn_down & ~btn_prev;

  always_ff @(posedge clock) begin
    // Tracked through reset too, so a button held across reset needs a fresh press.
    btn_prev <= btn_down;
    if (!reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      len        <= '0;
      abort_pend <= 1'b0;
      play_audio <= 1'b0;
      color      <= 2'd0;
      on_off     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cur_index  <= '0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      len        <= len_n;
      abort_pend <= abort_pend_n;
      play_audio <= play_n;
      color      <= color_n;
      on_off     <= on_off_n;
      busy       <= busy_n;
      done       <= done_n;
      cur_index  <= idx_n;
    end
  end

  always_comb begin
    state_n      = state;
    timer_n      = timer;
    idx_n        = cur_index;
    len_n        = len;
    abort_pend_n = 1'b0;
    play_n       = 1'b0;
    color_n      = color;
    on_off_n     = on_off;
    busy_n       = busy;
    done_n       = 1'b0;

    if (state != S_IDLE && (abort || abort_pend)) begin
      // An abort landing on a strobe cycle is held one cycle so strobes never abut.
      if (play_audio) begin
        abort_pend_n = 1'b1;
      end else begin
        state_n  = S_IDLE;
        timer_n  = '0;
        play_n   = 1'b1;
        on_off_n = 1'b0;
        busy_n   = 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (seq_len != '0) begin
              len_n    = (seq_len > DEPTH_LEN) ? DEPTH_LEN : seq_len;
              idx_n    = '0;
              timer_n  = '0;
              state_n  = S_TONE;
              play_n   = 1'b1;
              color_n  = ram[0];
              on_off_n = 1'b1;
              busy_n   = 1'b1;
            end else begin
              done_n = 1'b1;
            end
          end else if (btn_rise) begin
            state_n  = S_MANUAL;
            play_n   = 1'b1;
            color_n  = btn_color;
            on_off_n = 1'b1;
          end
        end

        S_TONE: begin
          if (timer == TONE_LAST) begin
            state_n  = S_GAP;
            timer_n  = '0;
            play_n   = 1'b1;
            on_off_n = 1'b0;
          end else begin
            timer_n = timer + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (timer == GAP_LAST) begin
            timer_n = '0;
            if (idx_inc < len) begin
              idx_n    = idx_inc[IDX_W-1:0];
              state_n  = S_TONE;
              play_n   = 1'b1;
              color_n  = ram[idx_inc[IDX_W-1:0]];
              on_off_n = 1'b1;
            end else begin
              state_n = S_IDLE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end
          end else begin
            timer_n = timer + CNT_W'(1);
          end
        end

        S_MANUAL: begin
          // Release right after the press strobe is taken a cycle later.
          if (!btn_down && !play_audio) begin
            state_n  = S_IDLE;
            play_n   = 1'b1;
            on_off_n = 1'b0;
          end
        end

        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sequencer.sv
// tb/tb_audio_sequencer.sv - directed checks of playback timing, manual tone, abort, reset and length clamp
module tb_audio_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       seq_wr_en;
  logic [4:0] seq_wr_addr;
  logic [1:0] seq_wr_color;
  logic [5:0] seq_len;
  logic       start;
  logic       abort;
  logic       btn_down;
  logic [1:0] btn_color;
  logic       play_audio;
  logic [1:0] color;
  logic       on_off;
  logic       busy;
  logic       done;
  logic [4:0] cur_index;

  int checks   = 0;
  int failures = 0;
  logic [1:0] ram_m [32];

  audio_sequencer #(
    .SEQ_DEPTH(32), .IDX_W(5), .TONE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(3)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .seq_wr_en(seq_wr_en), .seq_wr_addr(seq_wr_addr), .seq_wr_color(seq_wr_color),
    .seq_len(seq_len), .start(start), .abort(abort),
    .btn_down(btn_down), .btn_color(btn_color),
    .play_audio(play_audio), .color(color), .on_off(on_off),
    .busy(busy), .done(done), .cur_index(cur_index)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int addr, input logic [1:0] col);
    seq_wr_en    = 1'b1;
    seq_wr_addr  = addr[4:0];
    seq_wr_color = col;
    step();
    seq_wr_en = 1'b0;
    ram_m[addr] = col;
  endtask

  task automatic start_seq(input int len);
    seq_len = len[5:0];
    start   = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Caller has just entered cycle 0; tone k starts at 6k, gap at 6k+4, done at 6L.
  task automatic run_seq(input int l, input string name);
    int n_on;
    n_on = 0;
    for (int c = 0; c <= l * 6 + 1; c++) begin
      int  k, ph;
      logic e_busy, e_play;
      if (c > 0) step();
      k      = c / 6;
      ph     = c % 6;
      e_busy = (c < l * 6);
      e_play = e_busy && (ph == 0 || ph == 4);
      check({name, "_play"}, play_audio, e_play);
      check({name, "_busy"}, busy, e_busy);
      check({name, "_done"}, done, c == l * 6);
      if (e_play) begin
        check({name, "_color"}, color, ram_m[k]);
        check({name, "_onoff"}, on_off, ph == 0);
        check({name, "_idx"}, cur_index, k);
      end
      if (play_audio && on_off) n_on++;
    end
    check({name, "_tones"}, n_on, l);
  endtask

  initial begin
    reset_n = 1'b0; seq_wr_en = 1'b0; seq_wr_addr = '0; seq_wr_color = '0;
    seq_len = '0; start = 1'b0; abort = 1'b0; btn_down = 1'b0; btn_color = '0;
    repeat (3) step();
    check("rst_play", play_audio, 0);
    check("rst_color", color, 0);
    check("rst_onoff", on_off, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", cur_index, 0);
    reset_n = 1'b1;
    step();

    // Basic three-entry playback
    wr(0, 2); wr(1, 0); wr(2, 3);
    start_seq(3);
    run_seq(3, "seq3");

    // Zero length: immediate done, no strobe
    start_seq(0);
    check("len0_done", done, 1);
    check("len0_play", play_audio, 0);
    check("len0_busy", busy, 0);
    step();
    check("len0_done_clr", done, 0);

    // Manual tone, start and colour change ignored while held
    btn_color = 2'd1;
    btn_down  = 1'b1;
    step();
    check("man_play", play_audio, 1);
    check("man_color", color, 1);
    check("man_onoff", on_off, 1);
    btn_color = 2'd3;
    start = 1'b1; seq_len = 6'd3;
    step();
    start = 1'b0;
    check("man_hold_play", play_audio, 0);
    check("man_hold_busy", busy, 0);
    step(); step(); step();
    check("man_hold_color", color, 1);
    check("man_hold_on", on_off, 1);
    btn_down = 1'b0;
    step();
    check("man_rel_play", play_audio, 1);
    check("man_rel_onoff", on_off, 0);
    check("man_rel_color", color, 1);
    step();
    check("man_rel_once", play_audio, 0);

    // Abort at cycle 2 of {1,2}
    wr(0, 1); wr(1, 2);
    start_seq(2);
    check("abt_c0_play", play_audio, 1);
    check("abt_c0_color", color, 1);
    step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abt_play", play_audio, 1);
    check("abt_onoff", on_off, 0);
    check("abt_busy", busy, 0);
    for (int i = 0; i < 15; i++) begin
      step();
      check("abt_no_done", done, 0);
      check("abt_quiet", play_audio, 0);
    end

    // Reset in the middle of playback, then replay from index 0
    start_seq(2);
    repeat (5) step();
    reset_n = 1'b0;
    step();
    check("mrst_play", play_audio, 0);
    check("mrst_onoff", on_off, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_color", color, 0);
    reset_n = 1'b1;
    step();
    start_seq(2);
    run_seq(2, "replay");

    // Over-long request clamps to the RAM depth
    for (int i = 0; i < 32; i++) wr(i, 2'((i * 3 + 1) % 4));
    start_seq(40);
    run_seq(32, "clamp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
